// File: rtl/gpio_display_writer.sv
// Writes the LED register and six seven-segment HEX registers of a GPIO slave in one sequence.
// Define GPIO_READBACK_VERIFY_EN to read back and compare each written word.
module gpio_display_writer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] value,
  input  logic [3:0]  leds,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_cs,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [11:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  // Handshake: start is sampled only while idle; busy covers WRITE..DONE, done pulses once in DONE.
  localparam logic [11:0] BASE_ADDR = 12'h008;
  localparam logic [2:0]  LAST_K    = 3'd6;
  localparam logic [3:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef GPIO_READBACK_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, GAP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, GAP, DONE} state_t;
`endif

  state_t      state;
  logic [2:0]  k;
  logic [2:0]  k_next;
  logic [3:0]  gap_cnt;
  logic [23:0] value_q;
  logic [3:0]  leds_q;

  assign k_next = k + 3'd1;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Transaction 0 carries the LED pattern; transactions 1..6 carry HEX0..HEX5.
  function automatic logic [31:0] word_for(input logic [2:0] idx, input logic [23:0] v,
                                           input logic [3:0] l);
    logic [3:0] nib;
    case (idx)
      3'd1:    nib = v[3:0];
      3'd2:    nib = v[7:4];
      3'd3:    nib = v[11:8];
      3'd4:    nib = v[15:12];
      3'd5:    nib = v[19:16];
      3'd6:    nib = v[23:20];
      default: nib = 4'h0;
    endcase
    if (idx == 3'd0) return {28'h0, l};
    return {25'h0, seg(nib)};
  endfunction

  function automatic logic [11:0] addr_for(input logic [2:0] idx);
    return BASE_ADDR + {7'h0, idx, 2'b00};
  endfunction

`ifndef GPIO_READBACK_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;
  assign error        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 3'd0;
      gap_cnt   <= 4'd0;
      value_q   <= 24'h0;
      leds_q    <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_cs    <= 1'b0;
      bus_ren   <= 1'b0;
      bus_wen   <= 1'b0;
      bus_addr  <= 12'h0;
      bus_wdata <= 32'h0;
`ifdef GPIO_READBACK_VERIFY_EN
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            value_q   <= value;
            leds_q    <= leds;
            k         <= 3'd0;
            busy      <= 1'b1;
            state     <= WRITE;
            bus_cs    <= 1'b1;
            bus_wen   <= 1'b1;
            bus_ren   <= 1'b0;
            bus_addr  <= BASE_ADDR;
            bus_wdata <= word_for(3'd0, value, leds);
`ifdef GPIO_READBACK_VERIFY_EN
            error     <= 1'b0;
`endif
          end
        end
`ifdef GPIO_READBACK_VERIFY_EN
        WRITE: begin
          state     <= READ;
          bus_wen   <= 1'b0;
          bus_ren   <= 1'b1;
          bus_wdata <= 32'h0;
        end
        // With readback the end-of-transaction step below belongs to READ instead of WRITE.
        READ: begin
          if (bus_rdata != word_for(k, value_q, leds_q)) error <= 1'b1;
`else
        WRITE: begin
`endif
          if (k == LAST_K) begin
            state     <= DONE;
            done      <= 1'b1;
            bus_cs    <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= 12'h0;
            bus_wdata <= 32'h0;
          end else if (GAP_CYCLES > 0) begin
            state     <= GAP;
            gap_cnt   <= GAP_LOAD;
            k         <= k_next;
            bus_cs    <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= 12'h0;
            bus_wdata <= 32'h0;
          end else begin
            state     <= WRITE;
            k         <= k_next;
            bus_cs    <= 1'b1;
            bus_wen   <= 1'b1;
            bus_ren   <= 1'b0;
            bus_addr  <= addr_for(k_next);
            bus_wdata <= word_for(k_next, value_q, leds_q);
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state     <= WRITE;
            bus_cs    <= 1'b1;
            bus_wen   <= 1'b1;
            bus_ren   <= 1'b0;
            bus_addr  <= addr_for(k);
            bus_wdata <= word_for(k, value_q, leds_q);
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          k     <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_display_writer.sv
// Scoreboard bench for gpio_display_writer: one instance with no gap, one with GAP_CYCLES=2.
// Also builds with GPIO_READBACK_VERIFY_EN, where read cycles and the error flag are expected.
`timescale 1ns/1ps
module tb_gpio_display_writer;

`ifdef GPIO_READBACK_VERIFY_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int W     = 62;
  localparam int GAP_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start2;
  logic [23:0] value0, value2;
  logic [3:0]  leds0, leds2;
  logic        busy0, done0, error0, cs0, ren0, wen0;
  logic        busy2, done2, error2, cs2, ren2, wen2;
  logic [11:0] addr0, addr2;
  logic [31:0] wdata0, wdata2, rdata0, rdata2;
  logic        corrupt0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_display_writer dut0 (
    .clk(clk), .rst(rst), .start(start0), .value(value0), .leds(leds0),
    .busy(busy0), .done(done0), .error(error0), .bus_cs(cs0), .bus_ren(ren0),
    .bus_wen(wen0), .bus_addr(addr0), .bus_wdata(wdata0), .bus_rdata(rdata0)
  );

  gpio_display_writer #(.GAP_CYCLES(GAP_B)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .value(value2), .leds(leds2),
    .busy(busy2), .done(done2), .error(error2), .bus_cs(cs2), .bus_ren(ren2),
    .bus_wen(wen2), .bus_addr(addr2), .bus_wdata(wdata2), .bus_rdata(rdata2)
  );

  // GPIO slave model: stores writes, returns them on reads; corrupt0 forces 0 at offset 014.
  logic [31:0] mem0 [8];
  logic [31:0] mem2 [8];

  function automatic logic [2:0] slot(input logic [11:0] a);
    logic [11:0] off;
    off = a - 12'h008;
    return off[4:2];
  endfunction

  always @(posedge clk) begin
    if (cs0 && wen0) mem0[slot(addr0)] <= wdata0;
    if (cs2 && wen2) mem2[slot(addr2)] <= wdata2;
  end
  assign rdata0 = (corrupt0 && addr0 == 12'h014) ? 32'h0 : mem0[slot(addr0)];
  assign rdata2 = mem2[slot(addr2)];

  // Hand-computed register words, transaction 0 (LEDs) first, then HEX0..HEX5.
  logic [31:0] words_a [7] = '{32'h0A, 32'h12, 32'h19, 32'h30, 32'h24, 32'h79, 32'h40};
  logic [31:0] words_b [7] = '{32'h05, 32'h08, 32'h03, 32'h46, 32'h21, 32'h06, 32'h0E};
  logic [31:0] words_c [7] = '{32'h03, 32'h03, 32'h08, 32'h10, 32'h00, 32'h78, 32'h02};

  // Expected item: {cycle[15:0], wen, ren, addr[11:0], wdata[31:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_gap_q[$];
  int           done_q[$];
  int           done_gap_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bus(input int d, input logic [W-1:0] item);
    if (d == 0) exp_q.push_back(item);
    else exp_gap_q.push_back(item);
  endtask

  // Cycle n of a sequence (n=1 is the cycle after the accepting edge) is seen at cyc == acc+n-1.
  task automatic push_seq(input int d, input int acc, input logic [31:0] words [7],
                          input int gap, input int limit);
    int p;
    int n;
    p = (RB ? 2 : 1) + gap;
    for (int k = 0; k < 7; k++) begin
      n = 1 + p * k;
      if (limit == 0 || n <= limit)
        push_bus(d, {16'(acc + n - 1), 1'b1, 1'b0, 12'(12'h008 + 4 * k), words[k]});
      if (RB && (limit == 0 || n + 1 <= limit))
        push_bus(d, {16'(acc + n), 1'b0, 1'b1, 12'(12'h008 + 4 * k), 32'h0});
    end
    if (limit == 0) begin
      n = 1 + p * 6 + (RB ? 2 : 1);
      if (d == 0) done_q.push_back(acc + n - 1);
      else done_gap_q.push_back(acc + n - 1);
    end
  endtask

  task automatic mon_dut(input int d, input logic cs, input logic wen, input logic ren,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic dn, input logic bsy);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    int           dc;
    string        tag;
    bit           have;
    tag = (d == 0) ? "dut0" : "dut_gap";
    act = {16'(cyc), wen, ren, addr, wdata};
    if (cs) begin
      have = (d == 0) ? (exp_q.size() != 0) : (exp_gap_q.size() != 0);
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_bus: got %h, expected no bus cycle", tag, act);
      end else begin
        if (d == 0) exp = exp_q.pop_front();
        else exp = exp_gap_q.pop_front();
        check({tag, "_bus"}, 64'(act), 64'(exp));
      end
    end else begin
      check({tag, "_idle_bus"}, 64'({ren, wen, addr, wdata}), 64'(0));
    end
    if (dn) begin
      have = (d == 0) ? (done_q.size() != 0) : (done_gap_q.size() != 0);
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_done: got done at cycle %0d, expected none", tag, cyc);
      end else begin
        if (d == 0) dc = done_q.pop_front();
        else dc = done_gap_q.pop_front();
        check({tag, "_done_cycle"}, 64'(cyc), 64'(dc));
        check({tag, "_busy_in_done"}, 64'(bsy), 64'(1));
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_dut(0, cs0, wen0, ren0, addr0, wdata0, done0, busy0);
      mon_dut(1, cs2, wen2, ren2, addr2, wdata2, done2, busy2);
    end
  endtask

  task automatic begin_start(input int d, input logic [23:0] v, input logic [3:0] l,
                             output int acc);
    @(negedge clk);
    if (d == 0) begin
      start0 = 1'b1; value0 = v; leds0 = l;
    end else begin
      start2 = 1'b1; value2 = v; leds2 = l;
    end
    acc = cyc + 1;
  endtask

  // Inputs are scrambled once start drops: the running sequence must use the latched copy.
  task automatic end_start();
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    value0 = 24'($urandom_range(0, 32'hFFFFFF));
    value2 = 24'($urandom_range(0, 32'hFFFFFF));
    leds0  = 4'($urandom_range(0, 15));
    leds2  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle(input int d, input int budget);
    int t;
    bit fin;
    t = 0;
    fin = 1'b0;
    while (!fin && t < budget) begin
      @(negedge clk);
      #1;
      t++;
      if (d == 0) fin = !busy0 && exp_q.size() == 0 && done_q.size() == 0;
      else fin = !busy2 && exp_gap_q.size() == 0 && done_gap_q.size() == 0;
    end
    check((d == 0) ? "dut0_sequence_finished" : "dut_gap_sequence_finished",
          64'(fin), 64'(1));
  endtask

  initial begin
    int a;
    rst = 1'b1;
    start0 = 1'b0; start2 = 1'b0;
    value0 = 24'h0; value2 = 24'h0;
    leds0 = 4'h0; leds2 = 4'h0;
    corrupt0 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dut0", 64'({busy0, done0, error0, cs0, ren0, wen0, addr0, wdata0}), 64'(0));
    check("reset_dut_gap", 64'({busy2, done2, error2, cs2, ren2, wen2, addr2, wdata2}), 64'(0));
    rst = 1'b0;
    fork
      monitor();
    join_none

    // Basic sequence; slave corrupts the 014 readback when readback is built in.
    corrupt0 = 1'b1;
    begin_start(0, 24'h012345, 4'hA, a);
    push_seq(0, a, words_a, 0, 0);
    end_start();
    check("busy_after_accept", 64'(busy0), 64'(1));
    wait_idle(0, 100);
    check("error_after_seq_a", 64'(error0), 64'(RB));
    corrupt0 = 1'b0;

    // Gap instance
    begin_start(1, 24'hFEDCBA, 4'h5, a);
    push_seq(1, a, words_b, GAP_B, 0);
    end_start();
    wait_idle(1, 200);
    check("error_dut_gap", 64'(error2), 64'(0));

    // Second start in cycle 3 must be ignored; accepting this start clears error.
    begin_start(0, 24'h6789AB, 4'h3, a);
    push_seq(0, a, words_c, 0, 0);
    end_start();
    check("error_cleared_on_start", 64'(error0), 64'(0));
    @(negedge clk);
    @(negedge clk);
    start0 = 1'b1; value0 = 24'hFFFFFF; leds0 = 4'hF;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0, 100);

    // Reset during cycle 4 aborts the sequence.
    begin_start(0, 24'h012345, 4'hA, a);
    push_seq(0, a, words_a, 0, 4);
    end_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_abort", 64'(busy0), 64'(0));
    check("done_after_abort", 64'(done0), 64'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_queue_drained", 64'(exp_q.size() + done_q.size()), 64'(0));

    // Full sequence after the abort.
    begin_start(0, 24'h6789AB, 4'h3, a);
    push_seq(0, a, words_c, 0, 0);
    end_start();
    wait_idle(0, 100);
    check("error_after_restart", 64'(error0), 64'(0));

    repeat (3) @(negedge clk);
    check("final_queues_empty",
          64'(exp_q.size() + exp_gap_q.size() + done_q.size() + done_gap_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
